// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL reset/lock sequencer on the free-running reference clock
// Pulses PLL reset, waits for a stable lock, then releases the system reset; retries or faults on timeout.
module pll_rst_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int MAX_RETRY           = 4,
    parameter int CNT_W               = 17
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock_i,
    output logic       pll_reset_o,
    output logic       sys_resetn_o,
    output logic       pll_locked_o,
    output logic       fault_o,
    output logic [7:0] retry_cnt_o,
    output logic [7:0] loss_cnt_o
);

    typedef enum logic [2:0] {
        S_RST_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [15:0]      MAX_FAIL    = 16'(MAX_RETRY);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [15:0]      r_fail;
    logic [15:0]      w_fail_nxt;
    logic [15:0]      w_fail_inc;
    logic [7:0]       r_retry;
    logic [7:0]       w_retry_nxt;
    logic [7:0]       r_loss;
    logic [7:0]       w_loss_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_pll_reset;
    logic             r_sys_resetn;
    logic             r_locked;
    logic             r_fault;

    // Failed-attempt count only needs to exceed MAX_RETRY once, so saturation is harmless.
    assign w_fail_inc = (r_fail == 16'hFFFF) ? r_fail : r_fail + 16'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_fail_nxt  = r_fail;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;
        case (r_state)
            S_RST_PLL: begin
                if (r_cnt == RST_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (r_sync2) begin
                    w_state_nxt = S_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TO_LAST) begin
                    w_retry_nxt = (r_retry == 8'hFF) ? r_retry : r_retry + 8'd1;
                    w_fail_nxt  = w_fail_inc;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (w_fail_inc > MAX_FAIL) ? S_FAULT : S_RST_PLL;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_STABLE: begin
                if (!r_sync2) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                    w_fail_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!r_sync2) begin
                    w_state_nxt = S_RST_PLL;
                    w_cnt_nxt   = '0;
                    w_loss_nxt  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_RST_PLL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_state      <= S_RST_PLL;
            r_cnt        <= '0;
            r_fail       <= '0;
            r_retry      <= '0;
            r_loss       <= '0;
            r_pll_reset  <= 1'b1;
            r_sys_resetn <= 1'b0;
            r_locked     <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_sync1      <= pll_lock_i;
            r_sync2      <= r_sync1;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_fail       <= w_fail_nxt;
            r_retry      <= w_retry_nxt;
            r_loss       <= w_loss_nxt;
            r_pll_reset  <= (w_state_nxt == S_RST_PLL) || (w_state_nxt == S_FAULT);
            r_sys_resetn <= (w_state_nxt == S_RUN);
            r_locked     <= (w_state_nxt == S_RUN);
            r_fault      <= (w_state_nxt == S_FAULT);
        end
    end

    assign pll_reset_o  = r_pll_reset;
    assign sys_resetn_o = r_sys_resetn;
    assign pll_locked_o = r_locked;
    assign fault_o      = r_fault;
    assign retry_cnt_o  = r_retry;
    assign loss_cnt_o   = r_loss;

endmodule

// File: tb/tb_pll_rst_seq.sv
// tb/tb_pll_rst_seq.sv - directed table and sequence bench for pll_rst_seq
module tb_pll_rst_seq;

    logic       clk = 1'b0;
    logic       resetn;
    logic       lock;
    logic       pll_reset;
    logic       sys_resetn;
    logic       locked;
    logic       fault;
    logic [7:0] retry;
    logic [7:0] loss;

    logic       resetn2;
    logic       lock2;
    logic       pll_reset2;
    logic       sys_resetn2;
    logic       locked2;
    logic       fault2;
    logic [7:0] retry2;
    logic [7:0] loss2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_rst_seq #(
        .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRY(3), .CNT_W(17)
    ) dut (
        .clk(clk), .resetn(resetn), .pll_lock_i(lock), .pll_reset_o(pll_reset),
        .sys_resetn_o(sys_resetn), .pll_locked_o(locked), .fault_o(fault),
        .retry_cnt_o(retry), .loss_cnt_o(loss)
    );

    pll_rst_seq #(
        .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8), .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRY(1000), .CNT_W(17)
    ) dut_sat (
        .clk(clk), .resetn(resetn2), .pll_lock_i(lock2), .pll_reset_o(pll_reset2),
        .sys_resetn_o(sys_resetn2), .pll_locked_o(locked2), .fault_o(fault2),
        .retry_cnt_o(retry2), .loss_cnt_o(loss2)
    );

    typedef struct {
        logic       rn;
        logic       lk;
        int         n;
        logic       e_prst;
        logic       e_sys;
        logic       e_lck;
        logic       e_flt;
        logic [7:0] e_retry;
        logic [7:0] e_loss;
    } vec_t;

    vec_t vecs[12];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    initial begin
        // Normal lock, run, lock loss and relock, applied edge-count by edge-count.
        vecs[0]  = '{1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[3]  = '{1'b1, 1'b0, 6,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[4]  = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
        vecs[5]  = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0};
        vecs[7]  = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1};
        vecs[8]  = '{1'b1, 1'b0, 3,  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1};
        vecs[9]  = '{1'b1, 1'b0, 1,  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1};
        vecs[10] = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd1};
        vecs[11] = '{1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd1};

        resetn  = 1'b0;
        lock    = 1'b0;
        resetn2 = 1'b0;
        lock2   = 1'b0;

        for (int i = 0; i < 12; i++) begin
            resetn = vecs[i].rn;
            lock   = vecs[i].lk;
            step(vecs[i].n);
            chk($sformatf("vec%0d.pll_reset", i), pll_reset, vecs[i].e_prst);
            chk($sformatf("vec%0d.sys_resetn", i), sys_resetn, vecs[i].e_sys);
            chk($sformatf("vec%0d.locked", i), locked, vecs[i].e_lck);
            chk($sformatf("vec%0d.fault", i), fault, vecs[i].e_flt);
            chk($sformatf("vec%0d.retry", i), retry, vecs[i].e_retry);
            chk($sformatf("vec%0d.loss", i), loss, vecs[i].e_loss);
        end

        // Two failures, then RUN, then lock loss: four fresh failures allowed before FAULT.
        resetn = 1'b0; lock = 1'b0; step(2);
        resetn = 1'b1;
        step(36);  chk("fr.retry1", retry, 1);   chk("fr.prst1", pll_reset, 1);
        step(36);  chk("fr.retry2", retry, 2);
        lock = 1'b1;
        step(12);  chk("fr.sys_pre", sys_resetn, 0);
        step(1);   chk("fr.sys_run", sys_resetn, 1); chk("fr.retry_run", retry, 2);
        lock = 1'b0;
        step(3);   chk("fr.sys_loss", sys_resetn, 0); chk("fr.loss", loss, 1);
        step(72);  chk("fr.no_fault", fault, 0); chk("fr.retry4", retry, 4);
        step(71);  chk("fr.fault_pre", fault, 0);
        step(1);   chk("fr.fault", fault, 1); chk("fr.retry6", retry, 6); chk("fr.prst_f", pll_reset, 1);
        step(20);  chk("fr.fault_hold", fault, 1); chk("fr.sys_f", sys_resetn, 0);
        resetn = 1'b0;
        step(1);   chk("fr.rst_fault", fault, 0); chk("fr.rst_retry", retry, 0); chk("fr.rst_loss", loss, 0);

        // Lock never arrives: fault after the fourth timeout.
        resetn = 1'b1;
        step(108); chk("to.retry3", retry, 3); chk("to.prst3", pll_reset, 1);
        step(35);  chk("to.fault_pre", fault, 0); chk("to.prst_wait", pll_reset, 0);
        step(1);   chk("to.fault", fault, 1); chk("to.retry4", retry, 4); chk("to.prst", pll_reset, 1);
        resetn = 1'b0;
        step(1);   chk("to.rst_fault", fault, 0); chk("to.rst_prst", pll_reset, 1);

        // One-cycle lock glitch at the final stable count blocks the release.
        resetn = 1'b1; lock = 1'b1;
        step(10);
        lock = 1'b0; step(1);
        lock = 1'b1;
        step(2);   chk("gl.sys_blocked", sys_resetn, 0); chk("gl.prst", pll_reset, 0);
        step(8);   chk("gl.sys_pre", sys_resetn, 0);
        step(1);   chk("gl.sys_run", sys_resetn, 1); chk("gl.retry", retry, 0);

        // Reset asserted in WAIT_LOCK at cnt=20, then a clean lock.
        resetn = 1'b0; lock = 1'b0; step(2);
        resetn = 1'b1;
        step(24);  chk("mr.prst_wait", pll_reset, 0);
        resetn = 1'b0;
        step(1);   chk("mr.prst", pll_reset, 1); chk("mr.sys", sys_resetn, 0); chk("mr.lck", locked, 0);
        resetn = 1'b1; lock = 1'b1;
        step(12);  chk("mr.sys_pre", sys_resetn, 0);
        step(1);   chk("mr.sys_run", sys_resetn, 1); chk("mr.lck_run", locked, 1);

        // Retry counter saturation on the large-MAX_RETRY instance.
        resetn2 = 1'b0; step(2);
        resetn2 = 1'b1;
        step(9179); chk("sat.retry254", retry2, 254);
        step(1);    chk("sat.retry255", retry2, 255);
        step(1620); chk("sat.hold", retry2, 255); chk("sat.fault", fault2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
